// File: rtl/ascon_ad_ctrl.sv
// ASCON-128a associated-data absorption sequencer: packs 32-bit AD words into
// 128-bit padded rate blocks and drives an external p8 over start/done.
module ascon_ad_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  adlen,
    input  logic [319:0] s_in,
    input  logic [31:0]  ad_data,
    input  logic         ad_valid,
    output logic         ad_ready,
    output logic         perm_start,
    output logic [319:0] perm_state_out,
    input  logic         perm_done,
    input  logic [319:0] perm_state_in,
    output logic         busy,
    output logic         done,
    output logic [319:0] s_out
);

    // PADBLK is a reserved encoding: the pad-only block is absorbed directly on PWAIT exit.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PADBLK = 3'd2,
        PSTART = 3'd3,
        PWAIT  = 3'd4,
        FINAL  = 3'd5
    } fsm_t;

    localparam logic [319:0] PAD_ONLY = {8'h80, 312'd0};
    localparam logic [319:0] DOM_SEP  = 320'd1;

    fsm_t           fsm_r;
    logic [319:0]   state_r;
    logic [31:0]    rem_r;
    logic [127:0]   blk_r;
    logic [1:0]     idx_r;
    logic [4:0]     bcnt_r;
    logic           pad_pending_r;
    logic           perm_start_r;
    logic [319:0]   perm_state_out_r;
    logic           busy_r;
    logic           done_r;
    logic [319:0]   s_out_r;

    logic [2:0]     take_s;
    logic [31:0]    mask_s;
    logic [31:0]    word_s;
    logic [127:0]   blk_word_s;
    logic [127:0]   blk_pad_s;
    logic [31:0]    rem_next_s;
    logic [4:0]     bcnt_next_s;
    logic           close_s;
    logic           pad_set_s;
    logic [319:0]   absorb_s;

    assign ad_ready       = (fsm_r == LOAD);
    assign perm_start     = perm_start_r;
    assign perm_state_out = perm_state_out_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign s_out          = s_out_r;

    // Word packing, byte accounting, padding and rate absorption for the current handshake.
    always_comb begin
        take_s = (rem_r >= 32'd4) ? 3'd4 : rem_r[2:0];
        case (take_s)
            3'd1:    mask_s = 32'hFF00_0000;
            3'd2:    mask_s = 32'hFFFF_0000;
            3'd3:    mask_s = 32'hFFFF_FF00;
            3'd4:    mask_s = 32'hFFFF_FFFF;
            default: mask_s = 32'h0000_0000;
        endcase
        word_s     = ad_data & mask_s;
        blk_word_s = blk_r;
        case (idx_r)
            2'd0:    blk_word_s[127:96] = word_s;
            2'd1:    blk_word_s[95:64]  = word_s;
            2'd2:    blk_word_s[63:32]  = word_s;
            2'd3:    blk_word_s[31:0]   = word_s;
            default: blk_word_s         = blk_r;
        endcase
        rem_next_s  = rem_r - {29'd0, take_s};
        bcnt_next_s = bcnt_r + {2'd0, take_s};
        close_s     = (idx_r == 2'd3) || (rem_next_s == 32'd0);
        pad_set_s   = (rem_next_s == 32'd0) && (bcnt_next_s == 5'd16);
        blk_pad_s   = blk_word_s;
        if (rem_next_s == 32'd0) begin
            for (int b = 0; b < 16; b++) begin
                if (bcnt_next_s == 5'(b)) begin
                    blk_pad_s[127 - 8*b -: 8] = 8'h80;
                end else begin
                    blk_pad_s[127 - 8*b -: 8] = blk_word_s[127 - 8*b -: 8];
                end
            end
        end else begin
            blk_pad_s = blk_word_s;
        end
        absorb_s = {state_r[319:192] ^ blk_pad_s, state_r[191:0]};
    end

    // Control FSM with registered handshake outputs and state datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r            <= IDLE;
            state_r          <= 320'd0;
            rem_r            <= 32'd0;
            blk_r            <= 128'd0;
            idx_r            <= 2'd0;
            bcnt_r           <= 5'd0;
            pad_pending_r    <= 1'b0;
            perm_start_r     <= 1'b0;
            perm_state_out_r <= 320'd0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            s_out_r          <= 320'd0;
        end else begin
            perm_start_r <= 1'b0;
            done_r       <= 1'b0;
            case (fsm_r)
                IDLE: begin
                    if (start) begin
                        state_r       <= s_in;
                        rem_r         <= adlen;
                        blk_r         <= 128'd0;
                        idx_r         <= 2'd0;
                        bcnt_r        <= 5'd0;
                        pad_pending_r <= 1'b0;
                        busy_r        <= 1'b1;
                        if (adlen == 32'd0) begin
                            s_out_r <= s_in ^ DOM_SEP;
                            done_r  <= 1'b1;
                            fsm_r   <= FINAL;
                        end else begin
                            fsm_r <= LOAD;
                        end
                    end else begin
                        fsm_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (ad_valid && ad_ready) begin
                        rem_r <= rem_next_s;
                        if (close_s) begin
                            state_r          <= absorb_s;
                            perm_state_out_r <= absorb_s;
                            perm_start_r     <= 1'b1;
                            pad_pending_r    <= pad_set_s;
                            blk_r            <= 128'd0;
                            idx_r            <= 2'd0;
                            bcnt_r           <= 5'd0;
                            fsm_r            <= PSTART;
                        end else begin
                            blk_r  <= blk_word_s;
                            idx_r  <= idx_r + 2'd1;
                            bcnt_r <= bcnt_next_s;
                        end
                    end else begin
                        fsm_r <= LOAD;
                    end
                end
                PSTART: begin
                    fsm_r <= PWAIT;
                end
                PWAIT: begin
                    if (perm_done) begin
                        if (rem_r != 32'd0) begin
                            state_r <= perm_state_in;
                            fsm_r   <= LOAD;
                        end else if (pad_pending_r) begin
                            pad_pending_r    <= 1'b0;
                            state_r          <= perm_state_in ^ PAD_ONLY;
                            perm_state_out_r <= perm_state_in ^ PAD_ONLY;
                            perm_start_r     <= 1'b1;
                            fsm_r            <= PSTART;
                        end else begin
                            state_r <= perm_state_in;
                            s_out_r <= perm_state_in ^ DOM_SEP;
                            done_r  <= 1'b1;
                            fsm_r   <= FINAL;
                        end
                    end else begin
                        fsm_r <= PWAIT;
                    end
                end
                FINAL: begin
                    busy_r <= 1'b0;
                    fsm_r  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    fsm_r  <= IDLE;
                end
            endcase
        end
    end

endmodule
